vga_pattern_scheduler: RTL and testbench
========================================

Name: vga_pattern_scheduler

Overview:
- Sequences which test pattern drives the VGA video path.
- Advances the pattern automatically every N frames, or on a manual "next" pulse, or on a direct select handshake.
- Pattern changes only at frame boundaries (vsync falling edge), so no frame ever tears; optionally blanks video for whole frames during a switch.
- Sits between the sync generator (supplies vsync) and the pattern generator / porch stage (consume o_pattern, o_blank).

Parameters:
- PAT_W, 4, width of the pattern index.
- NUM_PATTERNS, 6, number of valid patterns; legal indices 0..NUM_PATTERNS-1 (must be ≤ 2**PAT_W).
- FRAMES_PER_PATTERN, 120, frames each pattern is shown in auto mode (≥1).
- BLANK_FRAMES, 1, whole frames of forced black inserted on a switch (0 = none).

Ports:
- i_clk  in  1  pixel clock, 25 MHz.
- i_rst_n  in  1  reset, active-low.
- i_vsync  in  1  vsync from sync generator, active-low pulse, i_clk domain.
- i_auto_en  in  1  1 = auto-advance enabled.
- i_next  in  1  single-cycle request: advance to the next pattern.
- i_sel_valid  in  1  direct select request valid.
- i_sel  in  PAT_W  requested pattern index.
- o_sel_ready  out  1  scheduler can accept a select/next request.
- o_pattern  out  PAT_W  current pattern index.
- o_blank  out  1  1 = downstream forces RGB to 0.
- o_frame_tick  out  1  one-cycle pulse per frame start.

Behaviour:
- Clocking and reset:
  - One clock; reset is asynchronous and active-low, port i_rst_n.
  - Reset values: o_pattern=0, o_blank=0, o_frame_tick=0, state=S_SHOW (so o_sel_ready=1), frame counter=0, pending index=0, vsync delay register=1.
  - Assertion mid-switch abandons the switch; state returns to the reset values.
- Frame start detection:
  - fs = vs_d & ~i_vsync, where vs_d is i_vsync registered once.
  - o_frame_tick is fs registered, so it lags the falling edge by 1 cycle.
- Next-index rule: o_pattern==NUM_PATTERNS-1 → 0, else o_pattern+1.
- FSM states (registered): S_SHOW, S_PEND, S_BLANK. o_sel_ready = (state==S_SHOW).
- S_SHOW:
  - Frame counter (width $clog2(FRAMES_PER_PATTERN)+1) increments on fs while i_auto_en=1; it holds when i_auto_en=0.
  - Request priority:
    1. i_sel_valid&&o_sel_ready.
    2. i_next.
    3. Auto expiry.
  - Direct select with i_sel<NUM_PATTERNS: latch i_sel as the pending index, go to S_PEND.
  - Direct select with i_sel≥NUM_PATTERNS: consumed (handshake completes) but ignored; stay in S_SHOW.
  - i_next: latch the next index, go to S_PEND.
  - Auto expiry = fs && i_auto_en && counter==FRAMES_PER_PATTERN-1. It takes effect on that same fs: treated as the S_PEND→switch transition in the same cycle.
  - A manual request in the same cycle as auto expiry wins; the expiry is dropped and the counter holds.
- S_PEND: wait for the first fs strictly after entry.
  - On that fs with BLANK_FRAMES==0: o_pattern←pending, counter←0, go to S_SHOW.
  - On that fs with BLANK_FRAMES>0: o_blank←1, blank counter←0, go to S_BLANK.
- S_BLANK:
  - Blank counter increments on each fs.
  - On the fs where it reaches BLANK_FRAMES: o_pattern←pending, o_blank←0, frame counter←0, go to S_SHOW.
- Requests ignored in S_PEND/S_BLANK: i_next and i_sel_valid are dropped, not queued.
- Switching to the currently shown index is legal and still performs the blank sequence.

Optional Feature:
- Macro: VGA_SCHED_BLANK_EN.
- Defined: blanking as described above.
- Undefined:
  - S_BLANK is not built and BLANK_FRAMES is ignored.
  - o_blank is tied to 0.
  - S_PEND switches o_pattern directly at the next fs.

Decomposition:
- Shared package vga_pkg:
  - FSM state encodings S_SHOW=2'd0, S_PEND=2'd1, S_BLANK=2'd2.
  - 640x480@60 timing constants (800/525 totals, porch widths), shared with the sync/porch blocks.
- Sub-module vga_frame_edge: vsync delay register, fs detect, o_frame_tick register. Reusable by other frame-synchronous blocks.

Test Plan (NUM_PATTERNS=3, FRAMES_PER_PATTERN=3, BLANK_FRAMES=1, short synthetic frames of 20 clocks with a 2-clock low vsync):
- Reset, i_auto_en=1, run 12 frames → o_pattern steps 0→1 at frame 3 fs, then 1→2, 2→0. o_blank is high for exactly one frame each time. o_frame_tick is 1 cycle wide, 1 cycle after each falling edge.
- i_auto_en=0, pulse i_next mid-frame → o_sel_ready drops next cycle. Blank starts at the next fs; o_pattern=1 and o_blank=0 one frame later.
- i_sel_valid=1, i_sel=2, with i_next in the same cycle → pattern becomes 2, not 1.
- i_sel=5 (out of range) → handshake accepted, o_pattern and state unchanged, o_sel_ready stays 1.
- i_next during S_BLANK, and i_next on the auto-expiry fs → first is dropped. Second: manual wins, exactly one switch occurs.
- Assert i_rst_n low while in S_BLANK → o_pattern=0, o_blank=0, o_sel_ready=1 immediately. Repeat the auto scenario with VGA_SCHED_BLANK_EN undefined: o_blank stays 0 and the switch lands at the next fs.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared VGA definitions: scheduler FSM encodings and 640x480@60 timing constants
// used by the sync, porch and pattern-scheduling blocks.
package vga_pkg;

  typedef enum logic [1:0] {
    S_SHOW  = 2'd0,
    S_PEND  = 2'd1,
    S_BLANK = 2'd2
  } sched_state_e;

  localparam int H_VISIBLE = 640;
  localparam int H_FRONT   = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BACK    = 48;
  localparam int H_TOTAL   = 800;

  localparam int V_VISIBLE = 480;
  localparam int V_FRONT   = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 33;
  localparam int V_TOTAL   = 525;

endpackage

// File: rtl/vga_frame_edge.sv
// Frame-start detector: registers vsync once, flags its falling edge (o_fs, combinational)
// and provides a registered one-cycle frame tick that lags the edge by one clock.
module vga_frame_edge
  import vga_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_vsync,
  output logic o_fs,
  output logic o_frame_tick
);

  logic vs_q, vs_d;
  logic tick_q, tick_d;

  always_comb begin
    vs_d   = i_vsync;
    o_fs   = vs_q & ~i_vsync;
    tick_d = o_fs;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vs_q   <= 1'b1;
      tick_q <= 1'b0;
    end else begin
      vs_q   <= vs_d;
      tick_q <= tick_d;
    end
  end

  assign o_frame_tick = tick_q;

endmodule

// File: rtl/vga_pattern_scheduler.sv
// Test-pattern scheduler: switches the pattern index only at frame starts, from auto
// expiry, a next pulse or a direct select. Optional blank frames via VGA_SCHED_BLANK_EN.
//
// state   | meaning
// S_SHOW  | pattern displayed; accepts requests, counts frames for auto advance
// S_PEND  | switch requested; waits for the next frame start
// S_BLANK | video forced black for BLANK_FRAMES whole frames before the new pattern
module vga_pattern_scheduler
  import vga_pkg::*;
#(
  parameter int PAT_W              = 4,
  parameter int NUM_PATTERNS       = 6,
  parameter int FRAMES_PER_PATTERN = 120,
  parameter int BLANK_FRAMES       = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_vsync,
  input  logic             i_auto_en,
  input  logic             i_next,
  input  logic             i_sel_valid,
  input  logic [PAT_W-1:0] i_sel,
  output logic             o_sel_ready,
  output logic [PAT_W-1:0] o_pattern,
  output logic             o_blank,
  output logic             o_frame_tick
);

  localparam int               FCW      = $clog2(FRAMES_PER_PATTERN) + 1;
  localparam logic [FCW-1:0]   FC_LAST  = FCW'(FRAMES_PER_PATTERN - 1);
  localparam logic [PAT_W-1:0] PAT_LAST = PAT_W'(NUM_PATTERNS - 1);

  sched_state_e     state_q, state_d;
  logic [PAT_W-1:0] pattern_q, pattern_d;
  logic [PAT_W-1:0] pend_q, pend_d;
  logic [FCW-1:0]   fcnt_q, fcnt_d;
  logic [PAT_W-1:0] next_idx, start_idx, land_idx;
  logic             fs, start_sw, land;

`ifdef VGA_SCHED_BLANK_EN
  localparam int             BCW     = $clog2(BLANK_FRAMES + 1) + 1;
  localparam logic [BCW-1:0] BC_LAST = BCW'(BLANK_FRAMES);

  logic           blank_q, blank_d;
  logic [BCW-1:0] bcnt_q, bcnt_d;
`else
  logic unused_blank_cfg;
  assign unused_blank_cfg = (BLANK_FRAMES != 0);
`endif

  vga_frame_edge u_frame_edge (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_vsync      (i_vsync),
    .o_fs         (fs),
    .o_frame_tick (o_frame_tick)
  );

  always_comb begin
    next_idx = (pattern_q == PAT_LAST) ? '0 : pattern_q + PAT_W'(1);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= S_SHOW;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    pend_d    = pend_q;
    fcnt_d    = fcnt_q;
    start_sw  = 1'b0;
    start_idx = pend_q;
    land      = 1'b0;
    land_idx  = pend_q;
`ifdef VGA_SCHED_BLANK_EN
    blank_d   = blank_q;
    bcnt_d    = bcnt_q;
`endif

    case (state_q)
      S_SHOW: begin
        // Manual requests outrank auto expiry; an out-of-range select is consumed silently.
        if (i_sel_valid) begin
          if (i_sel <= PAT_LAST) begin
            pend_d  = i_sel;
            state_d = S_PEND;
          end
        end else if (i_next) begin
          pend_d  = next_idx;
          state_d = S_PEND;
        end else if (fs && i_auto_en) begin
          if (fcnt_q == FC_LAST) begin
            start_sw  = 1'b1;
            start_idx = next_idx;
          end else begin
            fcnt_d = fcnt_q + FCW'(1);
          end
        end
      end
      S_PEND: begin
        if (fs) start_sw = 1'b1;
      end
`ifdef VGA_SCHED_BLANK_EN
      S_BLANK: begin
        if (fs) begin
          if (bcnt_q + BCW'(1) == BC_LAST) land = 1'b1;
          else                             bcnt_d = bcnt_q + BCW'(1);
        end
      end
`endif
      default: state_d = S_SHOW;
    endcase

    // Auto expiry skips S_PEND: the expiring frame start is itself the switch point.
    if (start_sw) begin
      pend_d   = start_idx;
      land_idx = start_idx;
`ifdef VGA_SCHED_BLANK_EN
      if (BLANK_FRAMES > 0) begin
        blank_d = 1'b1;
        bcnt_d  = '0;
        state_d = S_BLANK;
      end else begin
        land = 1'b1;
      end
`else
      land = 1'b1;
`endif
    end

    if (land) begin
      pattern_d = land_idx;
      fcnt_d    = '0;
      state_d   = S_SHOW;
`ifdef VGA_SCHED_BLANK_EN
      blank_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pattern_q <= '0;
      pend_q    <= '0;
      fcnt_q    <= '0;
`ifdef VGA_SCHED_BLANK_EN
      blank_q   <= 1'b0;
      bcnt_q    <= '0;
`endif
    end else begin
      pattern_q <= pattern_d;
      pend_q    <= pend_d;
      fcnt_q    <= fcnt_d;
`ifdef VGA_SCHED_BLANK_EN
      blank_q   <= blank_d;
      bcnt_q    <= bcnt_d;
`endif
    end
  end

  always_comb begin
    o_sel_ready = (state_q == S_SHOW);
    o_pattern   = pattern_q;
`ifdef VGA_SCHED_BLANK_EN
    o_blank     = blank_q;
`else
    o_blank     = 1'b0;
`endif
  end

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Bench for vga_pattern_scheduler with short synthetic 20-clock frames; a frame-level
// reference model predicts pattern, blank, tick and ready every cycle.
module tb_vga_pattern_scheduler;

  localparam int PAT_W     = 4;
  localparam int NP        = 3;
  localparam int FPP       = 3;
  localparam int BF        = 1;
  localparam int FRAME_LEN = 20;
`ifdef VGA_SCHED_BLANK_EN
  localparam bit BLANK_EN = 1'b1;
`else
  localparam bit BLANK_EN = 1'b0;
`endif
  localparam bit USE_BLANK = BLANK_EN && (BF > 0);

  localparam int M_SHOW  = 0;
  localparam int M_WAIT  = 1;
  localparam int M_BLACK = 2;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_vsync;
  logic             i_auto_en;
  logic             i_next;
  logic             i_sel_valid;
  logic [PAT_W-1:0] i_sel;
  logic             o_sel_ready;
  logic [PAT_W-1:0] o_pattern;
  logic             o_blank;
  logic             o_frame_tick;

  int n_pass  = 0;
  int n_total = 0;
  int pos     = 0;

  bit m_vs_d, m_tick, m_blank;
  int m_pat, m_pend, m_mode, m_left, m_blank_left;

  vga_pattern_scheduler #(
    .PAT_W              (PAT_W),
    .NUM_PATTERNS       (NP),
    .FRAMES_PER_PATTERN (FPP),
    .BLANK_FRAMES       (BF)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_vsync      (i_vsync),
    .i_auto_en    (i_auto_en),
    .i_next       (i_next),
    .i_sel_valid  (i_sel_valid),
    .i_sel        (i_sel),
    .o_sel_ready  (o_sel_ready),
    .o_pattern    (o_pattern),
    .o_blank      (o_blank),
    .o_frame_tick (o_frame_tick)
  );

  always #5 i_clk = ~i_clk;

  // ---------------- reference model (frame-level rules) ----------------
  task automatic model_reset();
    m_vs_d = 1'b1; m_tick = 1'b0; m_blank = 1'b0;
    m_pat = 0; m_pend = 0; m_mode = M_SHOW; m_left = FPP; m_blank_left = 0;
  endtask

  task automatic model_land();
    m_pat = m_pend; m_blank = 1'b0; m_left = FPP; m_mode = M_SHOW;
  endtask

  task automatic model_begin_switch(input int p);
    m_pend = p;
    if (USE_BLANK) begin
      m_blank = 1'b1; m_blank_left = BF; m_mode = M_BLACK;
    end else begin
      model_land();
    end
  endtask

  task automatic model_clock(input bit vs, input bit auto_en, input bit nxt,
                             input bit sv, input int sel);
    bit frame_start;
    frame_start = m_vs_d && !vs;
    m_vs_d = vs;
    m_tick = frame_start;
    case (m_mode)
      M_SHOW: begin
        if (sv) begin
          if (sel < NP) begin m_pend = sel; m_mode = M_WAIT; end
        end else if (nxt) begin
          m_pend = (m_pat + 1) % NP; m_mode = M_WAIT;
        end else if (frame_start && auto_en) begin
          if (m_left == 1) model_begin_switch((m_pat + 1) % NP);
          else             m_left = m_left - 1;
        end
      end
      M_WAIT: if (frame_start) model_begin_switch(m_pend);
      default: if (frame_start) begin
        m_blank_left = m_blank_left - 1;
        if (m_blank_left == 0) model_land();
      end
    endcase
  endtask

  function automatic logic [PAT_W+2:0] dut_obs();
    return {o_pattern, o_blank, o_frame_tick, o_sel_ready};
  endfunction

  function automatic logic [PAT_W+2:0] model_obs();
    return {PAT_W'(m_pat), m_blank, m_tick, (m_mode == M_SHOW)};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic step(input bit nxt, input bit sv, input int sel);
    i_vsync     = !(pos == 2 || pos == 3);
    i_next      = nxt;
    i_sel_valid = sv;
    i_sel       = PAT_W'(sel);
    @(posedge i_clk);
    model_clock(i_vsync, i_auto_en, nxt, sv, sel);
    pos = (pos + 1) % FRAME_LEN;
    @(negedge i_clk);
  endtask

  task automatic apply_reset();
    i_rst_n = 1'b0; i_next = 1'b0; i_sel_valid = 1'b0; i_sel = '0; i_vsync = 1'b1;
    model_reset();
    pos = 0;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    i_auto_en = 1'b1;
    apply_reset();
    n_total++;
    if (dut_obs() !== {PAT_W'(0), 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_values: got %h want %h", dut_obs(), {PAT_W'(0), 3'b001});
    else n_pass++;
    step(1'b0, 1'b0, 0);
    n_total++;
    if (dut_obs() !== model_obs())
      $display("FAIL reset_first_cycle: got %h want %h", dut_obs(), model_obs());
    else n_pass++;
  endtask

  task automatic test_auto();
    int changes[$];
    int blank_cycles, ticks, prev_pat;
    bit prev_tick, wide_tick;
    i_auto_en = 1'b1;
    apply_reset();
    blank_cycles = 0; ticks = 0; prev_pat = 0; prev_tick = 0; wide_tick = 0;
    for (int k = 0; k < 12 * FRAME_LEN; k++) begin
      step(1'b0, 1'b0, 0);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL auto cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
      if (o_pattern !== PAT_W'(prev_pat)) begin
        changes.push_back(int'(o_pattern));
        prev_pat = int'(o_pattern);
      end
      if (o_blank === 1'b1) blank_cycles++;
      if (o_frame_tick === 1'b1) begin
        ticks++;
        if (prev_tick) wide_tick = 1'b1;
      end
      prev_tick = (o_frame_tick === 1'b1);
    end
    n_total++;
    if (ticks != 12 || wide_tick)
      $display("FAIL auto_ticks: got %0d (wide=%0d) want 12 (wide=0)", ticks, wide_tick);
    else n_pass++;
    n_total++;
    if (blank_cycles != (USE_BLANK ? 3 * FRAME_LEN : 0))
      $display("FAIL auto_blank_cycles: got %0d want %0d", blank_cycles,
               USE_BLANK ? 3 * FRAME_LEN : 0);
    else n_pass++;
    n_total++;
    if (USE_BLANK ? (changes.size() != 3 || changes[0] != 1 || changes[1] != 2 || changes[2] != 0)
                  : (changes.size() != 4 || changes[0] != 1 || changes[1] != 2 ||
                     changes[2] != 0 || changes[3] != 1))
      $display("FAIL auto_sequence: got %0d changes, last pattern %0d", changes.size(), prev_pat);
    else n_pass++;
  endtask

  task automatic test_next();
    i_auto_en = 1'b0;
    apply_reset();
    for (int k = 0; k < 51; k++) begin
      step(k == 10, 1'b0, 0);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL next cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
      if (k == 10) begin
        n_total++;
        if (o_sel_ready !== 1'b0) $display("FAIL next_ready_drop: got %b want 0", o_sel_ready);
        else n_pass++;
      end
      if (k == 25) begin
        n_total++;
        if (o_blank !== USE_BLANK) $display("FAIL next_blank_mid: got %b want %b", o_blank, USE_BLANK);
        else n_pass++;
      end
    end
    n_total++;
    if ({o_pattern, o_blank, o_sel_ready} !== {PAT_W'(1), 1'b0, 1'b1})
      $display("FAIL next_final: got pat=%0d blank=%b ready=%b want 1/0/1",
               o_pattern, o_blank, o_sel_ready);
    else n_pass++;
  endtask

  task automatic test_sel_priority();
    i_auto_en = 1'b0;
    apply_reset();
    for (int k = 0; k < 51; k++) begin
      step(k == 10, k == 10, 2);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL sel_prio cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
    end
    n_total++;
    if (o_pattern !== PAT_W'(2)) $display("FAIL sel_prio_final: got %0d want 2", o_pattern);
    else n_pass++;
  endtask

  task automatic test_sel_out_of_range();
    i_auto_en = 1'b0;
    apply_reset();
    for (int k = 0; k < 51; k++) begin
      step(1'b0, k == 10, 5);
      if (k == 10) begin
        n_total++;
        if ({o_pattern, o_blank, o_sel_ready} !== {PAT_W'(0), 1'b0, 1'b1})
          $display("FAIL sel_oor_accept: got pat=%0d blank=%b ready=%b want 0/0/1",
                   o_pattern, o_blank, o_sel_ready);
        else n_pass++;
      end
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL sel_oor cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
    end
    n_total++;
    if (o_pattern !== PAT_W'(0)) $display("FAIL sel_oor_final: got %0d want 0", o_pattern);
    else n_pass++;
  endtask

  task automatic test_drop_in_switch();
    i_auto_en = 1'b0;
    apply_reset();
    for (int k = 0; k < 80; k++) begin
      step(k == 10 || k == 15 || (USE_BLANK && k == 30), 1'b0, 0);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL drop cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
    end
    n_total++;
    if (o_pattern !== PAT_W'(1)) $display("FAIL drop_final: got %0d want 1", o_pattern);
    else n_pass++;
  endtask

  task automatic test_manual_vs_expiry();
    int changes, prev_pat;
    i_auto_en = 1'b1;
    apply_reset();
    changes = 0; prev_pat = 0;
    for (int k = 0; k < 103; k++) begin
      step(k == 2 * FRAME_LEN + 2, 1'b0, 0);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL manual_vs_exp cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
      if (k > 2 * FRAME_LEN + 2 && o_pattern !== PAT_W'(prev_pat)) changes++;
      prev_pat = int'(o_pattern);
    end
    n_total++;
    if (changes != 1 || o_pattern !== PAT_W'(1))
      $display("FAIL manual_vs_exp_once: got %0d switches to %0d want 1 switch to 1",
               changes, o_pattern);
    else n_pass++;
  endtask

  task automatic test_reset_mid_switch();
    int n_steps;
    i_auto_en = 1'b0;
    apply_reset();
    n_steps = USE_BLANK ? 36 : 16;
    for (int k = 0; k < n_steps; k++) step(k == 10, 1'b0, 0);
    n_total++;
    if (o_sel_ready !== 1'b0 || m_mode == M_SHOW || o_blank !== USE_BLANK)
      $display("FAIL mid_switch_entry: got ready=%b blank=%b want ready=0 blank=%b",
               o_sel_ready, o_blank, USE_BLANK);
    else n_pass++;
    i_rst_n = 1'b0;
    #1;
    n_total++;
    if ({o_pattern, o_blank, o_sel_ready} !== {PAT_W'(0), 1'b0, 1'b1})
      $display("FAIL reset_mid_switch: got pat=%0d blank=%b ready=%b want 0/0/1",
               o_pattern, o_blank, o_sel_ready);
    else n_pass++;
    model_reset();
    pos = 0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 50; k++) begin
      step(1'b0, 1'b0, 0);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL post_reset cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit nxt, sv;
    int sel;
    i_auto_en = 1'b1;
    apply_reset();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(0, 63) == 0) i_auto_en = ~i_auto_en;
      nxt = ($urandom_range(0, 15) == 0);
      sv  = ($urandom_range(0, 15) == 0);
      sel = int'($urandom_range(0, 7));
      step(nxt, sv, sel);
      n_total++;
      if (dut_obs() !== model_obs())
        $display("FAIL random cyc%0d: got %h want %h", k, dut_obs(), model_obs());
      else n_pass++;
    end
  endtask

  initial begin
    i_rst_n = 1'b0; i_auto_en = 1'b0; i_next = 1'b0; i_sel_valid = 1'b0;
    i_sel = '0; i_vsync = 1'b1;
    test_reset();
    test_auto();
    test_next();
    test_sel_priority();
    test_sel_out_of_range();
    test_drop_in_switch();
    test_manual_vs_expiry();
    test_reset_mid_switch();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
